// File: rtl/int_accept_seq_pkg.sv
// Shared CPU package: interrupt-entry sequencer state encoding and constants.
// Included by the core and by int_accept_seq.
package int_accept_seq_pkg;

    typedef enum logic [2:0] {
        IAS_IDLE,
        IAS_VFETCH,
        IAS_PUSH_SR,
        IAS_PUSH_PC,
        IAS_RD_VEC,
        IAS_DONE
    } IntSeqState_t;

    localparam logic [3:0] NMI_LEVEL = 4'hF;

    function automatic logic [31:0] vec_table_addr(
        input logic [31:0] vbr,
        input logic [7:0]  vec,
        input int          shift
    );
        return vbr + (32'(vec) << shift);
    endfunction

endpackage

// File: rtl/int_accept_seq.sv
// SH-2 style interrupt entry sequencer: accept, vector fetch, push SR/PC,
// read vector table, hand new PC/SP/IMASK to the core.
module int_accept_seq
    import int_accept_seq_pkg::*;
#(
    parameter int VEC_SHIFT = 2,
    parameter int STK_STEP  = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_LVL,
    input  logic [7:0]  INT_VEC,
    input  logic [3:0]  INT_MASK,
    input  logic        INST_BND,
    input  logic [31:0] VBR,
    input  logic [31:0] SP_IN,
    input  logic [31:0] SR_IN,
    input  logic [31:0] PC_IN,
    output logic        INT_ACP,
    output logic        INT_ACK,
    output logic        VECT_REQ,
    input  logic        VECT_WAIT,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_DO,
    input  logic [31:0] MEM_DI,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic        MEM_BUSY,
    output logic [31:0] NEW_PC,
    output logic [31:0] NEW_SP,
    output logic [3:0]  NEW_IMASK,
    output logic        DONE
);

    IntSeqState_t r_state;
    logic [31:0]  r_sp;
    logic [31:0]  r_sr;
    logic [31:0]  r_pc;
    logic [7:0]   r_vec;
    logic         r_vok;

    logic w_accept;
    logic w_bus_done;

    // NMI arrives as level 15 and must win even against a mask of 15.
    assign w_accept = INT_REQ && INST_BND &&
                      ((INT_LVL > INT_MASK) || (INT_LVL == NMI_LEVEL));

    assign w_bus_done = MEM_REQ && !MEM_BUSY;

    always_comb begin
        MEM_A   = '0;
        MEM_DO  = '0;
        MEM_WE  = 1'b0;
        MEM_REQ = 1'b0;
        unique case (r_state)
            IAS_PUSH_SR: begin
                MEM_A   = r_sp - 32'(STK_STEP);
                MEM_DO  = r_sr;
                MEM_WE  = 1'b1;
                MEM_REQ = 1'b1;
            end
            IAS_PUSH_PC: begin
                MEM_A   = r_sp - 32'(2 * STK_STEP);
                MEM_DO  = r_pc;
                MEM_WE  = 1'b1;
                MEM_REQ = 1'b1;
            end
            IAS_RD_VEC: begin
                MEM_A   = vec_table_addr(VBR, r_vec, VEC_SHIFT);
                MEM_REQ = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IAS_IDLE;
            r_sp      <= '0;
            r_sr      <= '0;
            r_pc      <= '0;
            r_vec     <= '0;
            r_vok     <= 1'b0;
            INT_ACP   <= 1'b0;
            INT_ACK   <= 1'b0;
            VECT_REQ  <= 1'b0;
            NEW_PC    <= '0;
            NEW_SP    <= '0;
            NEW_IMASK <= '0;
            DONE      <= 1'b0;
        end else begin
            // Vector-ready is sampled on the falling phase, consumed on the rising.
            if (CE_F && r_state == IAS_VFETCH && !VECT_WAIT)
                r_vok <= 1'b1;
            if (CE_R) begin
                INT_ACK <= 1'b0;
                DONE    <= 1'b0;
                unique case (r_state)
                    IAS_IDLE: begin
                        if (w_accept) begin
                            r_sp      <= SP_IN;
                            r_sr      <= SR_IN;
                            r_pc      <= PC_IN;
                            NEW_IMASK <= INT_LVL;
                            NEW_SP    <= SP_IN - 32'(2 * STK_STEP);
                            INT_ACP   <= 1'b1;
                            VECT_REQ  <= 1'b1;
                            r_vok     <= 1'b0;
                            r_state   <= IAS_VFETCH;
                        end
                    end
                    IAS_VFETCH: begin
                        if (r_vok) begin
                            r_vec    <= INT_VEC;
                            INT_ACK  <= 1'b1;
                            VECT_REQ <= 1'b0;
                            r_vok    <= 1'b0;
                            r_state  <= IAS_PUSH_SR;
                        end
                    end
                    IAS_PUSH_SR: begin
                        if (w_bus_done)
                            r_state <= IAS_PUSH_PC;
                    end
                    IAS_PUSH_PC: begin
                        if (w_bus_done)
                            r_state <= IAS_RD_VEC;
                    end
                    IAS_RD_VEC: begin
                        if (w_bus_done) begin
                            NEW_PC  <= MEM_DI;
                            DONE    <= 1'b1;
                            r_state <= IAS_DONE;
                        end
                    end
                    IAS_DONE: begin
                        INT_ACP <= 1'b0;
                        r_state <= IAS_IDLE;
                    end
                    default: r_state <= IAS_IDLE;
                endcase
            end
        end
    end

endmodule
